// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, decryption-order rotation schedule and widths.
// Used by the key schedulers and the round datapath.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;

  localparam logic [3:0] LAST_IDX = 4'd15;

  // Entries are DES bit numbers (1 = MSB of the source vector).
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Right-rotation applied when leaving decryption round index i-1 for index i.
  localparam logic [1:0] RSHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } sched_state_e;

  // Right rotation moves DES bit n to bit n+1 and bit 28 wraps to bit 1.
  function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] h,
                                                  input logic [1:0]        n);
    case (n)
      2'd1:    return {h[0], h[HALF_W-1:1]};
      2'd2:    return {h[1:0], h[HALF_W-1:2]};
      default: return h;
    endcase
  endfunction

endpackage

// File: rtl/des_dec_key_sched_if.sv
// Subkey stream from a key scheduler to the DES round datapath (valid/ready).
interface des_dec_key_sched_if;
  import des_pkg::*;

  logic [SUBKEY_W-1:0] subkey;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [3:0]          round_idx;

  modport master (output subkey, subkey_valid, round_idx, input  subkey_ready);
  modport slave  (input  subkey, subkey_valid, round_idx, output subkey_ready);
endinterface

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: selects the 48 subkey bits from the 56-bit {C,D} state.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey_o[SUBKEY_W-1-i] = cd_i[CD_W - PC2_TBL[i]];
  end

  // DES bits 9,18,22,25,35,38,43,54 are dropped by PC2.
  logic unused_cd;
  assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                       cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key scheduler: emits K16..K1 one per handshake by
// rotating C/D right from the PC1 load, so no subkey is ever stored.
module des_dec_key_sched
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 start,
  des_dec_key_sched_if.master  sk_if,
  output logic                 busy,
  output logic                 done
);

  sched_state_e        state_q;
  logic [HALF_W-1:0]   c_q, d_q;
  logic [HALF_W-1:0]   c_d, d_d;
  logic [3:0]          round_idx_q;
  logic [3:0]          idx_nxt;
  logic                done_q;
  logic [CD_W-1:0]     pc1_key;
  logic [SUBKEY_W-1:0] subkey_w;
  logic                xfer;

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign pc1_key[CD_W-1-i] = key_in[KEY_W - PC1_TBL[i]];
  end

  // Parity bits (DES bits 8,16,..,64) never reach the schedule.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign idx_nxt = round_idx_q + 4'd1;
  assign c_d     = rotr_half(c_q, RSHIFT[idx_nxt]);
  assign d_d     = rotr_half(d_q, RSHIFT[idx_nxt]);
  assign xfer    = (state_q == ST_EMIT) && sk_if.subkey_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      c_q         <= '0;
      d_q         <= '0;
      round_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            c_q         <= pc1_key[CD_W-1:HALF_W];
            d_q         <= pc1_key[HALF_W-1:0];
            round_idx_q <= '0;
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            if (round_idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              c_q         <= c_d;
              d_q         <= d_d;
              round_idx_q <= idx_nxt;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey_w)
  );

  assign sk_if.subkey       = subkey_w;
  assign sk_if.subkey_valid = (state_q == ST_EMIT);
  assign sk_if.round_idx    = round_idx_q;
  assign busy               = (state_q == ST_EMIT);
  assign done               = done_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Scoreboard bench for des_dec_key_sched: a bit-level DES key schedule model
// generates K1..K16, the expected stream is K16..K1 checked by a negedge monitor.
module tb_des_dec_key_sched;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        start;
  logic        busy;
  logic        done;

  des_dec_key_sched_if sk_if ();

  des_dec_key_sched dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .start  (start),
    .sk_if  (sk_if),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  // Standard encryption left-shift schedule, rounds 1..16.
  localparam int SHIFTS_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_STD    = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PARITY = 64'h123456789ABCDEF0;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   exp_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Forward DES schedule with left shifts; decryption order is its reverse.
  task automatic push_expected(input logic [63:0] key);
    logic [47:0] ks [16];
    bit c [28];
    bit d [28];
    bit tc, td;
    int p;
    exp_t e;
    for (int j = 0; j < 28; j++) begin
      c[j] = key[64 - PC1_T[j]];
      d[j] = key[64 - PC1_T[j + 28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS_T[r]; s++) begin
        tc = c[0];
        td = d[0];
        for (int j = 0; j < 27; j++) begin
          c[j] = c[j + 1];
          d[j] = d[j + 1];
        end
        c[27] = tc;
        d[27] = td;
      end
      for (int k = 0; k < 48; k++) begin
        p = PC2_T[k];
        ks[r][47 - k] = (p <= 28) ? c[p - 1] : d[p - 29];
      end
    end
    for (int i = 0; i < 16; i++) begin
      e.sk  = ks[15 - i];
      e.idx = i[3:0];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every presented subkey must match the queue head, stalled or not.
  initial begin
    exp_t front;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        chk("done_pulse", 64'(done), 64'(exp_done));
        exp_done = 1'b0;
        if (sk_if.subkey_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_subkey: got %h idx %0d expected none", sk_if.subkey, sk_if.round_idx);
          end else begin
            front = exp_q[0];
            chk("subkey", 64'(sk_if.subkey), 64'(front.sk));
            chk("round_idx", 64'(sk_if.round_idx), 64'(front.idx));
            if (sk_if.subkey_ready) begin
              void'(exp_q.pop_front());
              if (front.idx == 4'd15) exp_done = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic wait_idx(input logic [3:0] tgt);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (sk_if.subkey_valid && sk_if.round_idx == tgt) hit = 1'b1;
    end
    if (!hit) fail_now("wait_idx");
  endtask

  task automatic drain(input bit rnd_ready, input string name);
    for (int cyc = 0; cyc < 400 && exp_q.size() != 0; cyc++) begin
      sk_if.subkey_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      fail_now(name);
      exp_q.delete();
    end
    sk_if.subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_sched(input logic [63:0] key, input bit rnd_ready);
    push_expected(key);
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom};
    drain(rnd_ready, "run_sched_timeout");
  endtask

  initial begin
    logic [63:0] ka, kb;
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    sk_if.subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(sk_if.subkey_valid), 64'd0);
    chk("rst_idx", 64'(sk_if.round_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_subkey", 64'(sk_if.subkey), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer schedule with ready held high.
    push_expected(KEY_STD);
    key_in = KEY_STD;
    start = 1'b1;
    sk_if.subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom};
    chk("kat_valid", 64'(sk_if.subkey_valid), 64'd1);
    chk("kat_busy", 64'(busy), 64'd1);
    chk("kat_k16", 64'(sk_if.subkey), 64'h0000CB3D8B0E17F5);
    chk("kat_idx0", 64'(sk_if.round_idx), 64'd0);
    @(posedge clk); #1;
    chk("kat_k15", 64'(sk_if.subkey), 64'h0000BF918D3D3F0A);
    wait_idx(4'd15);
    chk("kat_k1", 64'(sk_if.subkey), 64'h00001B02EFFC7072);
    @(posedge clk); #1;
    chk("kat_done", 64'(done), 64'd1);
    chk("kat_busy_after", 64'(busy), 64'd0);
    chk("kat_valid_after", 64'(sk_if.subkey_valid), 64'd0);
    @(posedge clk); #1;
    chk("kat_done_once", 64'(done), 64'd0);
    chk("kat_all_sent", 64'(exp_q.size()), 64'd0);
    sk_if.subkey_ready = 1'b0;

    run_sched(KEY_STD, 1'b1);
    run_sched(KEY_PARITY, 1'b0);
    run_sched(64'd0, 1'b0);
    for (int t = 0; t < 4; t++) run_sched({$urandom, $urandom}, 1'b1);

    // start mid-schedule is ignored; reset mid-schedule aborts without done.
    ka = {$urandom, $urandom};
    kb = ~ka;
    push_expected(ka);
    key_in = ka;
    start = 1'b1;
    sk_if.subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idx(4'd5);
    start = 1'b1;
    key_in = kb;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idx(4'd9);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(sk_if.subkey_valid), 64'd0);
    chk("mid_rst_idx", 64'(sk_if.round_idx), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    sk_if.subkey_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_no_done", 64'(done), 64'd0);
    run_sched(ka, 1'b1);

    // start held high: the next schedule begins straight after done.
    ka = {$urandom, $urandom};
    push_expected(ka);
    push_expected(ka);
    key_in = ka;
    start = 1'b1;
    sk_if.subkey_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk); #1;
      if (done) hit = 1'b1;
    end
    if (!hit) fail_now("cont_done");
    chk("cont_valid_at_done", 64'(sk_if.subkey_valid), 64'd0);
    chk("cont_remaining", 64'(exp_q.size()), 64'd16);
    @(posedge clk); #1;
    chk("cont_restart_valid", 64'(sk_if.subkey_valid), 64'd1);
    chk("cont_restart_idx", 64'(sk_if.round_idx), 64'd0);
    start = 1'b0;
    key_in = {$urandom, $urandom};
    drain(1'b0, "cont_timeout");
    chk("cont_idle", 64'(sk_if.subkey_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
